// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor types, widths, ALU commands and branch targets
package proc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HALT} fsm_state_t;

  localparam int PC_W  = 10;
  localparam int IDX_W = 4;

  localparam logic [2:0] CMD_CMP = 3'b110;
  localparam logic [2:0] CMD_BR  = 3'b111;

  localparam int BR_DEPTH = 2 ** IDX_W;

  // Stored wider than PC_W so a narrower PC simply truncates the constants.
  localparam logic [15:0] BR_TARGETS [0:BR_DEPTH-1] = '{
    16'h000, 16'h100, 16'h080, 16'h040,
    16'h200, 16'h3F0, 16'h000, 16'h000,
    16'h000, 16'h000, 16'h000, 16'h000,
    16'h000, 16'h000, 16'h000, 16'h000
  };

endpackage

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - combinational branch-target ROM indexed by the instruction immediate
module branch_lut #(
  parameter int PC_W  = proc_pkg::PC_W,
  parameter int IDX_W = proc_pkg::IDX_W
) (
  input  logic [IDX_W-1:0] br_idx_i,
  output logic [PC_W-1:0]  target_o
);
  import proc_pkg::*;

  // Indices beyond the constant table read as address 0.
  always_comb begin
    target_o = '0;
    for (int i = 0; i < BR_DEPTH; i++) begin
      if (int'(br_idx_i) == i) begin
        target_o = PC_W'(BR_TARGETS[i]);
      end
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - program counter, branch flag and run/halt control
module fetch_pc_ctrl #(
  parameter int PC_W  = proc_pkg::PC_W,
  parameter int IDX_W = proc_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             cmp_valid,
  input  logic             br_logic,
  input  logic             br_en,
  input  logic [IDX_W-1:0] br_idx,
  input  logic             halt_req,
  output logic [PC_W-1:0]  pc,
  output logic             flag,
  output logic             running,
  output logic             done
);
  import proc_pkg::*;

  fsm_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] br_target;
  logic            flag_q, flag_d;
  logic            running_q, done_q;

  branch_lut #(.PC_W(PC_W), .IDX_W(IDX_W)) u_branch_lut (
    .br_idx_i (br_idx),
    .target_o (br_target)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flag_d  = flag_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          flag_d  = 1'b0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (halt_req) begin
            state_d = HALT;
          end else begin
            if (br_en && flag_q) begin
              pc_d   = br_target;
              flag_d = 1'b0;
            end else begin
              pc_d = pc_q + PC_W'(1);
            end
            // A CMP in the same cycle as a taken BR overrides the consume-clear.
            if (cmp_valid) begin
              flag_d = br_logic;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      flag_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      flag_q    <= flag_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == HALT);
    end
  end

  assign pc      = pc_q;
  assign flag    = flag_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - directed scoreboard bench for fetch_pc_ctrl
module tb_fetch_pc_ctrl;

  localparam int PC_W  = 10;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stall, cmp_valid, br_logic, br_en, halt_req;
  logic [IDX_W-1:0] br_idx;
  logic [PC_W-1:0]  pc;
  logic             flag, running, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string           tag;
    logic [PC_W-1:0] pc;
    logic            flag;
    logic            running;
    logic            done;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  fetch_pc_ctrl #(.PC_W(PC_W), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stall     (stall),
    .cmp_valid (cmp_valid),
    .br_logic  (br_logic),
    .br_en     (br_en),
    .br_idx    (br_idx),
    .halt_req  (halt_req),
    .pc        (pc),
    .flag      (flag),
    .running   (running),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_out(input exp_t e);
    chk({e.tag, ".pc"},      32'(pc),      32'(e.pc));
    chk({e.tag, ".flag"},    32'(flag),    32'(e.flag));
    chk({e.tag, ".running"}, 32'(running), 32'(e.running));
    chk({e.tag, ".done"},    32'(done),    32'(e.done));
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then check them.
  task automatic step(input logic st, input logic sl, input logic cv, input logic bl,
                      input logic be, input logic [IDX_W-1:0] bi, input logic hr,
                      input logic [PC_W-1:0] epc, input logic ef, input logic er,
                      input logic ed, input string tag);
    exp_t e;
    @(negedge clk);
    start = st; stall = sl; cmp_valid = cv; br_logic = bl;
    br_en = be; br_idx = bi; halt_req = hr;
    e.tag = tag; e.pc = epc; e.flag = ef; e.running = er; e.done = ed;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      compare_out(sb_q.pop_front());
    end
  endtask

  task automatic run1(input logic [PC_W-1:0] epc, input logic ef, input string tag);
    step(0, 0, 0, 0, 0, '0, 0, epc, ef, 1, 0, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    rst_n = 1'b0; start = 0; stall = 0; cmp_valid = 0; br_logic = 0;
    br_en = 0; br_idx = '0; halt_req = 0;
    repeat (3) @(posedge clk);
    #1;
    r.tag = "reset"; r.pc = '0; r.flag = 0; r.running = 0; r.done = 0;
    compare_out(r);

    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 1, 1, 1, 4'd3, 1, 10'h000, 0, 0, 0, "idle_ignore");
    step(1, 0, 0, 0, 0, '0, 0, 10'h000, 0, 1, 0, "start");
    for (int i = 1; i <= 5; i++) run1(PC_W'(i), 0, "count");

    // Asynchronous reset lands mid-cycle, away from any clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    r.tag = "async_reset"; r.pc = '0; r.flag = 0; r.running = 0; r.done = 0;
    compare_out(r);
    @(negedge clk);
    rst_n = 1'b1;

    step(1, 0, 0, 0, 0, '0, 0, 10'h000, 0, 1, 0, "restart");
    for (int i = 1; i <= 16; i++) run1(PC_W'(i), 0, "to_010");

    step(0, 0, 1, 1, 0, '0, 0, 10'h011, 1, 1, 0, "cmp_taken");
    step(0, 0, 0, 0, 1, 4'd3, 0, 10'h040, 0, 1, 0, "br_taken");
    step(0, 0, 1, 0, 0, '0, 0, 10'h041, 0, 1, 0, "cmp_not_taken");
    step(0, 0, 0, 0, 1, 4'd3, 0, 10'h042, 0, 1, 0, "br_not_taken");
    step(0, 0, 0, 1, 0, '0, 0, 10'h043, 0, 1, 0, "br_logic_no_cmp");

    step(0, 0, 1, 1, 0, '0, 0, 10'h044, 1, 1, 0, "set_flag_a");
    step(0, 0, 1, 0, 1, 4'd2, 0, 10'h080, 0, 1, 0, "cmp_br_new0");
    step(0, 0, 1, 1, 0, '0, 0, 10'h081, 1, 1, 0, "set_flag_b");
    step(0, 0, 1, 1, 1, 4'd2, 0, 10'h080, 1, 1, 0, "cmp_br_new1");
    step(0, 0, 0, 0, 1, 4'd15, 0, 10'h000, 0, 1, 0, "br_unused_entry");

    step(0, 0, 1, 1, 0, '0, 0, 10'h001, 1, 1, 0, "set_flag_c");
    step(0, 0, 0, 0, 1, 4'd5, 0, 10'h3F0, 0, 1, 0, "br_to_3f0");
    for (int i = 1; i <= 15; i++) run1(PC_W'(10'h3F0 + i), 0, "to_3ff");
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1, 4'd3, 1, 10'h3FF, 0, 1, 0, "stall_hold");
    run1(10'h000, 0, "wrap");

    for (int i = 1; i <= 10; i++) step(i == 5, 0, 0, 0, 0, '0, 0, PC_W'(i), 0, 1, 0, "to_00a");
    step(0, 0, 0, 0, 0, '0, 1, 10'h00A, 0, 0, 1, "halt");
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1, i[0], 4'd3, i[1], 10'h00A, 0, 0, 1, "halt_hold");
    step(1, 0, 0, 0, 0, '0, 0, 10'h000, 0, 1, 0, "halt_restart");
    run1(10'h001, 0, "after_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
